// File: rtl/axi_mm_pkg.sv
// Shared definitions for the AXI MM test path (burst generator and read-back checker).
//   AXI_BURST_INCR, AXI_RESP_OKAY : AXI encodings used on the AR/R channels
//   PATTERN_SEED_INIT             : first byte of the byte-incrementing pattern
//   chk_state_e                   : read-back checker state encoding
package axi_mm_pkg;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [7:0] PATTERN_SEED_INIT = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_DATA   = 2'd2,
        ST_FINISH = 2'd3
    } chk_state_e;

endpackage

// File: rtl/data_chk_axi_mm_burst_if.sv
// AXI4 read-address / read-data channel bundle used by the burst checker.
//   master : checker side (drives AR, consumes R)
//   slave  : memory side (accepts AR, drives R)
interface data_chk_axi_mm_burst_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);

    logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;
    logic [2:0]                m_axi_arprot;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot,
        output m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot,
        input  m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

endinterface

// File: rtl/data_pattern_gen.sv
// Byte-incrementing pattern word: byte i of word = seed + i (mod 256).
// Shared by the burst generator and the checker so both sides stay bit-identical.
//   seed : first byte of the word
//   word : AXI_DATA_WIDTH-bit pattern word
module data_pattern_gen #(
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic [7:0]                seed,
    output logic [AXI_DATA_WIDTH-1:0] word
);

    for (genvar i = 0; i < AXI_DATA_WIDTH / 8; i++) begin : g_byte
        assign word[8*i +: 8] = seed + 8'(i);
    end

endmodule

// File: rtl/data_chk_axi_mm_burst.sv
// AXI4 MM burst read-back checker. Reads REPEAT passes over a window of BYTES
// bytes at BASE_ADDR in fixed-length INCR bursts and compares each beat against
// the byte-incrementing pattern, reporting sticky error status.
//   ACLK, ARESETn       : clock, async active-low reset
//   BASE_ADDR/BYTES/REPEAT/START : run configuration, sampled on START in IDLE
//   BUSY, DONE          : run in progress / one-cycle end-of-run pulse
//   ERROR, ERR_COUNT, FIRST_ERR_ADDR : sticky failure status, cleared on START
//   axi                 : AR/R channels (master side)
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for START; status held from last run
// ST_ADDR   | arvalid high, araddr held until arready
// ST_DATA   | rready high, checking each R beat
// ST_FINISH | DONE pulse, back to IDLE next cycle
module data_chk_axi_mm_burst
    import axi_mm_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [15:0]               BYTES,
    input  logic [15:0]               REPEAT,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERROR,
    output logic [15:0]               ERR_COUNT,
    output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    data_chk_axi_mm_burst_if.master   axi
);

    localparam int                        BPB           = AXI_DATA_WIDTH / 8;
    localparam logic [7:0]                LAST_BEAT     = 8'(MAX_BURST_LEN - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BPB_A         = AXI_ADDR_WIDTH'(BPB);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES_A = AXI_ADDR_WIDTH'(MAX_BURST_LEN * BPB);
    localparam logic [31:0]               BPB_W         = 32'(BPB);

    chk_state_e                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]               bytes_q, bytes_d;
    logic [15:0]               repeat_q, repeat_d;
    logic [7:0]                seed_q, seed_d;
    logic [7:0]                beat_q, beat_d;
    // Wider than BYTES so the final burst of a pass cannot overflow it.
    logic [31:0]               bytes_read_q, bytes_read_d;
    logic [15:0]               pass_q, pass_d;
    logic                      error_q, error_d;
    logic [15:0]               err_cnt_q, err_cnt_d;
    logic [AXI_ADDR_WIDTH-1:0] first_err_q, first_err_d;

    logic [AXI_DATA_WIDTH-1:0] exp_word;
    logic [15:0]               last_pass;
    logic                      beat_fail;
    logic [AXI_ADDR_WIDTH-1:0] beat_addr;

    data_pattern_gen #(
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
    ) u_pattern (
        .seed(seed_q),
        .word(exp_word)
    );

    // REPEAT=0 behaves as a single pass.
    assign last_pass = (repeat_q == 16'd0) ? 16'd0 : repeat_q - 16'd1;
    assign beat_addr = addr_q + AXI_ADDR_WIDTH'(beat_q) * BPB_A;
    assign beat_fail = (axi.m_axi_rdata != exp_word)
                    || (axi.m_axi_rresp != AXI_RESP_OKAY)
                    || (axi.m_axi_rlast != (beat_q == LAST_BEAT));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        addr_d       = addr_q;
        bytes_d      = bytes_q;
        repeat_d     = repeat_q;
        seed_d       = seed_q;
        beat_d       = beat_q;
        bytes_read_d = bytes_read_q;
        pass_d       = pass_q;
        error_d      = error_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    base_d       = BASE_ADDR;
                    bytes_d      = BYTES;
                    repeat_d     = REPEAT;
                    addr_d       = BASE_ADDR;
                    seed_d       = PATTERN_SEED_INIT;
                    beat_d       = 8'd0;
                    bytes_read_d = 32'd0;
                    pass_d       = 16'd0;
                    error_d      = 1'b0;
                    err_cnt_d    = 16'd0;
                    first_err_d  = '0;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                beat_d = 8'd0;
                if (axi.m_axi_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.m_axi_rvalid) begin
                    if (beat_fail) begin
                        error_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        // ERROR is cleared on START, so its old value marks the first failure.
                        if (!error_q) begin
                            first_err_d = beat_addr;
                        end
                    end
                    seed_d       = seed_q + 8'd1;
                    beat_d       = beat_q + 8'd1;
                    bytes_read_d = bytes_read_q + BPB_W;
                    // Burst length is counted locally; a misplaced RLAST only flags an error.
                    if (beat_q == LAST_BEAT) begin
                        addr_d  = addr_q + BURST_BYTES_A;
                        state_d = ST_ADDR;
                        if (bytes_read_d >= {16'd0, bytes_q}) begin
                            if (pass_q == last_pass) begin
                                state_d = ST_FINISH;
                            end else begin
                                pass_d       = pass_q + 16'd1;
                                addr_d       = base_q;
                                seed_d       = PATTERN_SEED_INIT;
                                bytes_read_d = 32'd0;
                            end
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            addr_q       <= '0;
            bytes_q      <= 16'd0;
            repeat_q     <= 16'd0;
            seed_q       <= 8'd0;
            beat_q       <= 8'd0;
            bytes_read_q <= 32'd0;
            pass_q       <= 16'd0;
            error_q      <= 1'b0;
            err_cnt_q    <= 16'd0;
            first_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            bytes_q      <= bytes_d;
            repeat_q     <= repeat_d;
            seed_q       <= seed_d;
            beat_q       <= beat_d;
            bytes_read_q <= bytes_read_d;
            pass_q       <= pass_d;
            error_q      <= error_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
        end
    end

    assign BUSY           = (state_q != ST_IDLE);
    assign DONE           = (state_q == ST_FINISH);
    assign ERROR          = error_q;
    assign ERR_COUNT      = err_cnt_q;
    assign FIRST_ERR_ADDR = first_err_q;

    assign axi.m_axi_araddr  = addr_q;
    assign axi.m_axi_arlen   = LAST_BEAT;
    assign axi.m_axi_arsize  = 3'($clog2(BPB));
    assign axi.m_axi_arburst = AXI_BURST_INCR;
    assign axi.m_axi_arprot  = 3'b000;
    assign axi.m_axi_arvalid = (state_q == ST_ADDR);
    assign axi.m_axi_rready  = (state_q == ST_DATA);

endmodule
